// File: rtl/pipeline_hazard_controller.sv
// Hazard control for a 5-stage pipeline: stalls on load-use, flushes on taken
// branches, freezes the pipe on slow data memory, and halts on memory timeout.
module pipeline_hazard_controller #(
  parameter int MEM_TIMEOUT = 15,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4:0]             ID_RsAddress,
  input  logic [4:0]             ID_RtAddress,
  input  logic                   ID_UsesRs,
  input  logic                   ID_UsesRt,
  input  logic [4:0]             EX_WBAddress,
  input  logic                   EX_RegWriteEn,
  input  logic                   EX_MemRead,
  input  logic                   EX_BranchTaken,
  input  logic                   MEM_MemReq,
  input  logic                   MEM_MemReady,
  output logic                   PC_En,
  output logic                   IF_ID_En,
  output logic                   ID_EX_En,
  output logic                   EX_MEM_En,
  output logic                   IF_ID_Flush,
  output logic                   ID_EX_Bubble,
  output logic                   MEM_WB_Bubble,
  output logic [1:0]             Ctrl_State,
  output logic                   MemTimeoutErr,
  output logic [STALL_CNT_W-1:0] Stall_Count
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    MEMWAIT = 2'b01,
    HALT    = 2'b11
  } ctrlState_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  ctrlState_t state;
  logic [7:0] timeoutCnt;
  logic       rsHit;
  logic       rtHit;
  logic       loadUse;
  logic       freeze;

  assign Ctrl_State = state;

  always_comb begin
    rsHit   = ID_UsesRs && (ID_RsAddress == EX_WBAddress);
    rtHit   = ID_UsesRt && (ID_RtAddress == EX_WBAddress);
    loadUse = EX_MemRead && EX_RegWriteEn && (EX_WBAddress != 5'd0) && (rsHit || rtHit);
    freeze  = ((state == RUN) && MEM_MemReq && !MEM_MemReady) ||
              ((state == MEMWAIT) && !MEM_MemReady);
  end

  // Priority: reset, halt/freeze, branch flush, load-use, default.
  always_comb begin
    PC_En         = 1'b1;
    IF_ID_En      = 1'b1;
    ID_EX_En      = 1'b1;
    EX_MEM_En     = 1'b1;
    IF_ID_Flush   = 1'b0;
    ID_EX_Bubble  = 1'b0;
    MEM_WB_Bubble = 1'b0;
    if (!reset) begin
      PC_En     = 1'b0;
      IF_ID_En  = 1'b0;
      ID_EX_En  = 1'b0;
      EX_MEM_En = 1'b0;
    end else if ((state == HALT) || freeze) begin
      PC_En         = 1'b0;
      IF_ID_En      = 1'b0;
      ID_EX_En      = 1'b0;
      EX_MEM_En     = 1'b0;
      MEM_WB_Bubble = 1'b1;
    end else if (EX_BranchTaken) begin
      IF_ID_Flush  = 1'b1;
      ID_EX_Bubble = 1'b1;
    end else if (loadUse) begin
      PC_En        = 1'b0;
      IF_ID_En     = 1'b0;
      ID_EX_Bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= RUN;
      timeoutCnt    <= 8'd0;
      MemTimeoutErr <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          timeoutCnt <= 8'd0;
          if (MEM_MemReq && !MEM_MemReady) state <= MEMWAIT;
        end
        MEMWAIT: begin
          if (MEM_MemReady) begin
            state      <= RUN;
            timeoutCnt <= 8'd0;
          end else if (timeoutCnt == TIMEOUT_LAST) begin
            state         <= HALT;
            MemTimeoutErr <= 1'b1;
          end else begin
            timeoutCnt <= timeoutCnt + 8'd1;
          end
        end
        HALT:    state <= HALT;
        default: state <= RUN;
      endcase
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Stall_Count <= '0;
    end else if (!PC_En && (Stall_Count != {STALL_CNT_W{1'b1}})) begin
      Stall_Count <= Stall_Count + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench: default-parameter instance for stall/flush/freeze behaviour,
// small instance (timeout 4, 4-bit counter) for halt and counter saturation.
module tb_pipeline_hazard_controller;

  logic clk;
  logic reset;
  logic rstB;
  logic [4:0] rsAddr, rtAddr, wbAddr;
  logic usesRs, usesRt, regWr, memRd, brTaken, memReq, memRdy;

  logic pcEnA, ifIdEnA, idExEnA, exMemEnA, flushA, idBubA, wbBubA, errA;
  logic [1:0] stateA;
  logic [15:0] stallA;
  logic pcEnB, ifIdEnB, idExEnB, exMemEnB, flushB, idBubB, wbBubB, errB;
  logic [1:0] stateB;
  logic [3:0] stallB;

  logic [3:0] enA, enB;
  logic [2:0] flagsA, flagsB;
  assign enA    = {pcEnA, ifIdEnA, idExEnA, exMemEnA};
  assign flagsA = {flushA, idBubA, wbBubA};
  assign enB    = {pcEnB, ifIdEnB, idExEnB, exMemEnB};
  assign flagsB = {flushB, idBubB, wbBubB};

  int checks = 0;
  int passes = 0;

  pipeline_hazard_controller dutA (
    .clk(clk), .reset(reset),
    .ID_RsAddress(rsAddr), .ID_RtAddress(rtAddr),
    .ID_UsesRs(usesRs), .ID_UsesRt(usesRt),
    .EX_WBAddress(wbAddr), .EX_RegWriteEn(regWr), .EX_MemRead(memRd),
    .EX_BranchTaken(brTaken), .MEM_MemReq(memReq), .MEM_MemReady(memRdy),
    .PC_En(pcEnA), .IF_ID_En(ifIdEnA), .ID_EX_En(idExEnA), .EX_MEM_En(exMemEnA),
    .IF_ID_Flush(flushA), .ID_EX_Bubble(idBubA), .MEM_WB_Bubble(wbBubA),
    .Ctrl_State(stateA), .MemTimeoutErr(errA), .Stall_Count(stallA)
  );

  pipeline_hazard_controller #(.MEM_TIMEOUT(4), .STALL_CNT_W(4)) dutB (
    .clk(clk), .reset(rstB),
    .ID_RsAddress(rsAddr), .ID_RtAddress(rtAddr),
    .ID_UsesRs(usesRs), .ID_UsesRt(usesRt),
    .EX_WBAddress(wbAddr), .EX_RegWriteEn(regWr), .EX_MemRead(memRd),
    .EX_BranchTaken(brTaken), .MEM_MemReq(memReq), .MEM_MemReady(memRdy),
    .PC_En(pcEnB), .IF_ID_En(ifIdEnB), .ID_EX_En(idExEnB), .EX_MEM_En(exMemEnB),
    .IF_ID_Flush(flushB), .ID_EX_Bubble(idBubB), .MEM_WB_Bubble(wbBubB),
    .Ctrl_State(stateB), .MemTimeoutErr(errB), .Stall_Count(stallB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt,
                               input logic uRs, input logic uRt,
                               input logic [4:0] wb, input logic wr, input logic rd,
                               input logic br, input logic req, input logic rdy);
    rsAddr = rs; rtAddr = rt; usesRs = uRs; usesRt = uRt;
    wbAddr = wb; regWr = wr; memRd = rd; brTaken = br;
    memReq = req; memRdy = rdy;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  initial begin
    reset = 1'b0;
    rstB  = 1'b0;
    applyStimulus(5'd1, 5'd2, 1, 1, 5'd0, 0, 0, 1, 1, 0);
    #12;
    checkOutput("resetEn", 32'(enA), 32'h0);
    checkOutput("resetFlags", 32'(flagsA), 32'h0);
    checkOutput("resetState", 32'(stateA), 32'h0);
    checkOutput("resetStall", 32'(stallA), 32'h0);
    checkOutput("resetErr", 32'(errA), 32'h0);

    @(negedge clk); reset = 1'b1;
    applyStimulus(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0); #1;
    checkOutput("defaultEn", 32'(enA), 32'hF);
    checkOutput("defaultFlags", 32'(flagsA), 32'h0);

    // load to r5, ID reads r5 through Rt
    @(negedge clk); applyStimulus(5'd1, 5'd5, 1, 1, 5'd5, 1, 1, 0, 0, 0); #1;
    checkOutput("loadUseEn", 32'(enA), 32'h3);
    checkOutput("loadUseFlags", 32'(flagsA), 32'h2);
    checkOutput("loadUseStallBefore", 32'(stallA), 32'h0);

    @(negedge clk); applyStimulus(5'd1, 5'd0, 1, 1, 5'd0, 1, 1, 0, 0, 0); #1;
    checkOutput("loadUseStallAfter", 32'(stallA), 32'h1);
    checkOutput("r0NoStallEn", 32'(enA), 32'hF);
    checkOutput("r0NoStallFlags", 32'(flagsA), 32'h0);

    @(negedge clk); applyStimulus(5'd7, 5'd3, 0, 1, 5'd7, 1, 1, 0, 0, 0); #1;
    checkOutput("rsUnusedEn", 32'(enA), 32'hF);

    @(negedge clk); applyStimulus(5'd5, 5'd2, 1, 1, 5'd5, 1, 0, 0, 0, 0); #1;
    checkOutput("notLoadEn", 32'(enA), 32'hF);

    @(negedge clk); applyStimulus(5'd1, 5'd5, 1, 1, 5'd5, 1, 1, 1, 0, 0); #1;
    checkOutput("branchOverLoadEn", 32'(enA), 32'hF);
    checkOutput("branchOverLoadFlags", 32'(flagsA), 32'h6);
    checkOutput("branchStallCount", 32'(stallA), 32'h1);

    // memory freeze for three cycles with a branch pending
    @(negedge clk); applyStimulus(5'd1, 5'd5, 1, 1, 5'd5, 1, 1, 1, 1, 0); #1;
    checkOutput("freeze1En", 32'(enA), 32'h0);
    checkOutput("freeze1Flags", 32'(flagsA), 32'h1);
    checkOutput("freeze1State", 32'(stateA), 32'h0);
    @(negedge clk); #1;
    checkOutput("freeze2State", 32'(stateA), 32'h1);
    checkOutput("freeze2En", 32'(enA), 32'h0);
    checkOutput("freeze2Flags", 32'(flagsA), 32'h1);
    @(negedge clk); #1;
    checkOutput("freeze3State", 32'(stateA), 32'h1);
    @(negedge clk); applyStimulus(5'd1, 5'd5, 1, 1, 5'd5, 1, 1, 1, 1, 1); #1;
    checkOutput("releaseState", 32'(stateA), 32'h1);
    checkOutput("releaseEn", 32'(enA), 32'hF);
    checkOutput("releaseFlags", 32'(flagsA), 32'h6);

    @(negedge clk); applyStimulus(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0); #1;
    checkOutput("freshReqState", 32'(stateA), 32'h0);
    checkOutput("freezeStallCount", 32'(stallA), 32'h4);
    checkOutput("freshReqEn", 32'(enA), 32'h0);
    @(negedge clk); applyStimulus(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 1); #1;
    checkOutput("freshReleaseState", 32'(stateA), 32'h1);
    checkOutput("freshReleaseEn", 32'(enA), 32'hF);
    checkOutput("freshReleaseFlags", 32'(flagsA), 32'h0);

    // asynchronous reset while in MEMWAIT
    @(negedge clk); applyStimulus(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0); #1;
    checkOutput("stall5", 32'(stallA), 32'h5);
    @(negedge clk); #1;
    checkOutput("preResetWaitState", 32'(stateA), 32'h1);
    #3 reset = 1'b0; #1;
    checkOutput("asyncResetState", 32'(stateA), 32'h0);
    checkOutput("asyncResetStall", 32'(stallA), 32'h0);
    checkOutput("asyncResetEn", 32'(enA), 32'h0);
    checkOutput("asyncResetFlags", 32'(flagsA), 32'h0);
    @(negedge clk); reset = 1'b1;
    applyStimulus(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0); #1;
    checkOutput("postResetEn", 32'(enA), 32'hF);
    checkOutput("postResetState", 32'(stateA), 32'h0);
    @(negedge clk); #1;
    checkOutput("postResetStall", 32'(stallA), 32'h0);

    // timeout of 4 and 4-bit stall counter saturation
    @(negedge clk); rstB = 1'b1;
    applyStimulus(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0);
    repeat (4) @(negedge clk);
    #1;
    checkOutput("timeoutWaitState", 32'(stateB), 32'h1);
    checkOutput("timeoutWaitErr", 32'(errB), 32'h0);
    @(negedge clk); applyStimulus(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1, 1); #1;
    checkOutput("haltState", 32'(stateB), 32'h3);
    checkOutput("haltErr", 32'(errB), 32'h1);
    checkOutput("haltEn", 32'(enB), 32'h0);
    checkOutput("haltFlags", 32'(flagsB), 32'h1);
    checkOutput("haltStall", 32'(stallB), 32'h5);
    repeat (15) @(negedge clk);
    #1;
    checkOutput("haltHeldState", 32'(stateB), 32'h3);
    checkOutput("stallSaturated", 32'(stallB), 32'hF);
    #2 rstB = 1'b0; #1;
    checkOutput("haltResetState", 32'(stateB), 32'h0);
    checkOutput("haltResetErr", 32'(errB), 32'h0);
    checkOutput("haltResetStall", 32'(stallB), 32'h0);
    @(negedge clk); rstB = 1'b1;
    applyStimulus(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0); #1;
    checkOutput("afterHaltEn", 32'(enB), 32'hF);
    @(negedge clk); #1;
    checkOutput("afterHaltState", 32'(stateB), 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
